// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Purpose:
//   Multi-cycle restoring divider. One quotient bit is produced per clock,
//   MSB first, on operand magnitudes. Results are sign-corrected and
//   registered when the result is taken, one clock after the last step.
//
// Configuration:
//   SEQ_DIVIDER_SIGNED_EN - when defined, div_type_in = 1 selects signed
//   two's complement division. When undefined, the sign logic is not built,
//   div_type_in is ignored and every division is unsigned.
//
// Ports:
//   clk_in        in   1      clock, all state changes on the rising edge
//   rst_in        in   1      synchronous active-high reset
//   start_in      in   1      request a division (accepted in IDLE or DONE)
//   div_type_in   in   1      0 = unsigned, 1 = signed (sampled with start)
//   dividend_in   in   N_BIT  dividend (sampled with start)
//   divisor_in    in   N_BIT  divisor (sampled with start)
//   quot_out      out  N_BIT  quotient
//   rem_out       out  N_BIT  remainder
//   busy_out      out  1      high while a division is being iterated
//   done_out      out  1      one-cycle pulse, results valid
//   div_zero_out  out  1      divisor was zero for the current result
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int N_BIT = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             div_type_in,
  input  logic [N_BIT-1:0] dividend_in,
  input  logic [N_BIT-1:0] divisor_in,
  output logic [N_BIT-1:0] quot_out,
  output logic [N_BIT-1:0] rem_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             div_zero_out
);

  localparam int CNT_W = (N_BIT > 1) ? $clog2(N_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control and datapath state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Dividend magnitude shifts out of the top while quotient bits shift in
  // at the bottom; after the last step it holds the quotient magnitude.
  logic [N_BIT-1:0]   a_q, a_d;
  logic [N_BIT:0]     d_q, d_d;
  logic [N_BIT:0]     r_q, r_d;
  logic [N_BIT-1:0]   raw_dvd_q, raw_dvd_d;
  logic               zero_q, zero_d;

  // Registered outputs
  logic [N_BIT-1:0]   quot_q, quot_d;
  logic [N_BIT-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  // Operand preparation
  logic [N_BIT-1:0]   dvd_mag;
  logic [N_BIT:0]     dvs_mag;

  // Restoring step
  logic [N_BIT+1:0]   r_shift;
  logic [N_BIT+1:0]   trial;
  logic               fits;
  logic               load;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dvd_neg, dvs_neg;
  logic [N_BIT:0]     dvs_ext;

  // The most negative dividend negates to its own bit pattern, which read
  // as unsigned is exactly its magnitude, so N_BIT bits suffice there. The
  // divisor is widened by one bit so its magnitude always reads unsigned.
  assign dvd_neg = div_type_in & dividend_in[N_BIT-1];
  assign dvs_neg = div_type_in & divisor_in[N_BIT-1];
  assign dvs_ext = {dvs_neg, divisor_in};
  assign dvd_mag = dvd_neg ? -dividend_in : dividend_in;
  assign dvs_mag = dvs_neg ? -dvs_ext : dvs_ext;
`else
  logic               unused_div_type;

  assign unused_div_type = div_type_in;
  assign dvd_mag         = dividend_in;
  assign dvs_mag         = {1'b0, divisor_in};
`endif

  // Next-state, datapath step and result formation. Operands are accepted
  // in IDLE and also in DONE so that back-to-back divisions lose no cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    d_d        = d_q;
    r_d        = r_q;
    raw_dvd_d  = raw_dvd_q;
    zero_d     = zero_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    busy_d     = (state_q == CALC);
    done_d     = (state_q == DONE);

    r_shift = {r_q, a_q[N_BIT-1]};
    trial   = r_shift - {1'b0, d_q};
    fits    = ~trial[N_BIT+1];
    load    = start_in & ((state_q == IDLE) | (state_q == DONE));

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      CALC: begin
        r_d = fits ? trial[N_BIT:0] : r_shift[N_BIT:0];
        a_d = (a_q << 1) | N_BIT'(fits);
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        div_zero_d = zero_q;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = raw_dvd_q;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          quot_d = neg_quot_q ? -a_q : a_q;
          rem_d  = neg_rem_q ? -r_q[N_BIT-1:0] : r_q[N_BIT-1:0];
`else
          quot_d = a_q;
          rem_d  = r_q[N_BIT-1:0];
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d   = CALC;
      cnt_d     = CNT_W'(N_BIT - 1);
      a_d       = dvd_mag;
      d_d       = dvs_mag;
      r_d       = '0;
      raw_dvd_d = dividend_in;
      zero_d    = (divisor_in == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_d = dvd_neg ^ dvs_neg;
      neg_rem_d  = dvd_neg;
`endif
    end
  end

  // State register with synchronous reset; reset aborts any division.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      raw_dvd_q  <= '0;
      zero_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      d_q        <= d_d;
      r_q        <= r_d;
      raw_dvd_q  <= raw_dvd_d;
      zero_q     <= zero_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign quot_out     = quot_q;
  assign rem_out      = rem_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign div_zero_out = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Purpose:
//   Self-checking bench for seq_divider (N_BIT = 8). Expected results are
//   computed with integer arithmetic and queued when a division is issued;
//   a monitor pops and compares them on every done_out pulse. The main
//   sequence also checks reset values, busy/done timing, abort by reset
//   and back-to-back operation.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int N = 8;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] quot;
    logic [N-1:0] rem;
    logic         dz;
  } exp_t;

  logic         clk_in;
  logic         rst_in;
  logic         start_in;
  logic         div_type_in;
  logic [N-1:0] dividend_in;
  logic [N-1:0] divisor_in;
  logic [N-1:0] quot_out;
  logic [N-1:0] rem_out;
  logic         busy_out;
  logic         done_out;
  logic         div_zero_out;

  exp_t sbQueue[$];
  int   vectorCount = 0;
  int   missCount   = 0;

  seq_divider #(.N_BIT(N)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .div_type_in  (div_type_in),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .quot_out     (quot_out),
    .rem_out      (rem_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .div_zero_out (div_zero_out)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model built on native integer division
  function automatic exp_t computeExpected(input logic [N-1:0] dvd,
                                           input logic [N-1:0] dvs,
                                           input logic dtype);
    exp_t e;
    int   a;
    int   b;
    int   q;
    int   r;
    if (dvs == '0) begin
      e.quot = '1;
      e.rem  = dvd;
      e.dz   = 1'b1;
      return e;
    end
    if (dtype & SIGNED_BUILD) begin
      a = $signed(dvd);
      b = $signed(dvs);
    end else begin
      a = int'({24'd0, dvd});
      b = int'({24'd0, dvs});
    end
    q      = a / b;
    r      = a % b;
    e.quot = q[N-1:0];
    e.rem  = r[N-1:0];
    e.dz   = 1'b0;
    return e;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one division; the following rising edge samples it
  task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                               input logic dtype, input bit holdStart);
    dividend_in = dvd;
    divisor_in  = dvs;
    div_type_in = dtype;
    start_in    = 1'b1;
    sbQueue.push_back(computeExpected(dvd, dvs, dtype));
    tick();
    if (!holdStart) start_in = 1'b0;
  endtask

  // Issue a division and wait (bounded) for its done pulse
  task automatic runDivision(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                             input logic dtype, input bit checkTiming);
    bit found = 1'b0;
    applyStimulus(dvd, dvs, dtype, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (checkTiming && k <= 9) checkOutput("busy", 32'(busy_out), 32'(k <= 8));
      if (done_out === 1'b1) begin
        found = 1'b1;
        if (checkTiming) checkOutput("latency", k, 9);
        break;
      end
    end
    if (!found) checkOutput("doneTimeout", 0, 1);
    tick();
    if (checkTiming) checkOutput("donePulseWidth", 32'(done_out), 0);
  endtask

  // Scoreboard monitor: compare every done pulse against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (done_out === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("quot", 32'(quot_out), 32'(e.quot));
          checkOutput("rem", 32'(rem_out), 32'(e.rem));
          checkOutput("divZero", 32'(div_zero_out), 32'(e.dz));
        end
      end
    end
  end

  // Watchdog in case the DUT wedges the main sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int doneSeen;
    int firstDone;
    int secondDone;
    logic [N-1:0] rDvd;
    logic [N-1:0] rDvs;
    logic         rType;

    rst_in      = 1'b1;
    start_in    = 1'b0;
    div_type_in = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    tick();
    tick();
    checkOutput("resetQuot", 32'(quot_out), 0);
    checkOutput("resetRem", 32'(rem_out), 0);
    checkOutput("resetBusy", 32'(busy_out), 0);
    checkOutput("resetDone", 32'(done_out), 0);
    checkOutput("resetDivZero", 32'(div_zero_out), 0);
    rst_in = 1'b0;
    tick();

    $display("[TB] unsigned 100/7 with timing");
    runDivision(8'd100, 8'd7, 1'b0, 1'b1);
    checkOutput("q100by7", 32'(quot_out), 32'h0E);
    checkOutput("r100by7", 32'(rem_out), 32'h02);

    $display("[TB] -7/2 with div_type_in=1");
    runDivision(8'hF9, 8'h02, 1'b1, 1'b0);

    $display("[TB] most negative / -1");
    runDivision(8'h80, 8'hFF, 1'b1, 1'b0);

    $display("[TB] divide by zero with timing");
    runDivision(8'd7, 8'd0, 1'b0, 1'b1);
    runDivision(8'h85, 8'd0, 1'b1, 1'b0);

    $display("[TB] abort by reset");
    applyStimulus(8'd200, 8'd3, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    dividend_in = 8'd50;
    divisor_in  = 8'd5;
    start_in    = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    rst_in = 1'b1;
    sbQueue.delete();
    tick();
    rst_in = 1'b0;
    checkOutput("abortQuot", 32'(quot_out), 0);
    checkOutput("abortRem", 32'(rem_out), 0);
    checkOutput("abortBusy", 32'(busy_out), 0);
    checkOutput("abortDone", 32'(done_out), 0);
    checkOutput("abortDivZero", 32'(div_zero_out), 0);
    doneSeen = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (busy_out === 1'b1) doneSeen++;
      if (done_out === 1'b1) doneSeen++;
    end
    checkOutput("abortIdle", doneSeen, 0);

    $display("[TB] back-to-back 15/4 then 9/9");
    applyStimulus(8'd15, 8'd4, 1'b0, 1'b1);
    dividend_in = 8'd9;
    divisor_in  = 8'd9;
    sbQueue.push_back(computeExpected(8'd9, 8'd9, 1'b0));
    firstDone  = -1;
    secondDone = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done_out === 1'b1) begin
        if (firstDone < 0) begin
          firstDone = k;
          start_in  = 1'b0;
        end else begin
          secondDone = k;
          break;
        end
      end
    end
    start_in = 1'b0;
    checkOutput("b2bFirst", firstDone, 9);
    checkOutput("b2bGap", secondDone - firstDone, 9);
    checkOutput("b2bQuot", 32'(quot_out), 32'h01);
    checkOutput("b2bRem", 32'(rem_out), 32'h00);
    tick();

    $display("[TB] random operands");
    for (int i = 0; i < 12; i++) begin
      rDvd  = N'($urandom);
      rDvs  = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      rType = 1'($urandom_range(0, 1));
      runDivision(rDvd, rDvs, rType, 1'b0);
    end

    tick();
    tick();
    checkOutput("queueDrained", sbQueue.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N_BIT, default 8: operand, quotient and remainder width.
REQ-002 SHALL have port clk_in, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start_in, input, 1: request a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port div_type_in, input, 1: 0 = unsigned, 1 = signed two's complement; sampled with start_in.
REQ-006 SHALL have port dividend_in, input, N_BIT: dividend; sampled with start_in.
REQ-007 SHALL have port divisor_in, input, N_BIT: divisor; sampled with start_in.
REQ-008 SHALL have port quot_out, output, N_BIT: quotient.
REQ-009 SHALL have port rem_out, output, N_BIT: remainder.
REQ-010 SHALL have port busy_out, output, 1: high while in CALC.
REQ-011 SHALL have port done_out, output, 1: single-cycle pulse; results valid.
REQ-012 SHALL have port div_zero_out, output, 1: divisor was zero for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: start_in=1 SHALL latch the operands and div_type_in, load a bit counter with N_BIT-1, and move to CALC; start_in=0 SHALL keep IDLE.
REQ-015 CALC SHALL do one restoring shift/trial-subtract step per cycle on operand magnitudes, producing one quotient bit MSB-first.
REQ-016 CALC SHALL move to DONE after exactly N_BIT cycles; start_in SHALL be ignored in CALC.
REQ-017 DONE SHALL last one cycle with done_out=1, then go to IDLE, or back to CALC if start_in=1 (back-to-back accepted).
REQ-018 Latency: done_out SHALL be high in the cycle after the (N_BIT+1)th rising edge following the edge that sampled start_in (N_BIT=8: 9 edges).
REQ-019 quot_out, rem_out and div_zero_out SHALL update only on entry to DONE and hold until the next entry to DONE or reset.
REQ-020 Unsigned: quot_out = floor(dividend/divisor); rem_out = dividend - quot*divisor.
REQ-021 Signed: quotient SHALL truncate toward zero, negated if operand signs differ; remainder SHALL carry the dividend's sign; |rem| < |divisor|.
REQ-022 Signed -2^(N_BIT-1) / -1 SHALL give quot_out = 2^(N_BIT-1) bit pattern (wrap), rem_out=0, div_zero_out=0.
REQ-023 Divisor zero, either mode: full latency, quot_out all ones, rem_out = raw dividend, div_zero_out=1, no sign correction.
REQ-024 Magnitudes and partial remainder SHALL use N_BIT+1-bit internal width so that |−2^(N_BIT-1)| is representable.

Reset
REQ-025 rst_in=1 at a rising edge SHALL force IDLE, counter 0, quot_out=0, rem_out=0, busy_out=0, done_out=0, div_zero_out=0.
REQ-026 Reset SHALL have priority over start_in and SHALL abort an in-flight division with no done_out pulse.

Configuration
REQ-027 Macro SEQ_DIVIDER_SIGNED_EN defined: signed mode per REQ-021/022 SHALL be built.
REQ-028 Macro SEQ_DIVIDER_SIGNED_EN undefined: sign logic SHALL be omitted, div_type_in ignored, all divisions unsigned.

Verification
REQ-029 Unsigned 100/7, start at edge T0 -> busy_out high T1..T8, done_out high after T9, quot_out=0x0E, rem_out=0x02.
REQ-030 Signed -7/2 (0xF9/0x02), div_type_in=1 -> quot_out=0xFD, rem_out=0xFF; with SEQ_DIVIDER_SIGNED_EN undefined -> 0x7C, 0x01.
REQ-031 7/0 -> quot_out=0xFF, rem_out=0x07, div_zero_out=1, same latency as REQ-029.
REQ-032 Signed 0x80/0xFF -> quot_out=0x80, rem_out=0x00, div_zero_out=0.
REQ-033 Start 200/3, pulse start_in at 4th CALC cycle, then rst_in at 6th CALC cycle -> start ignored, no done_out, all outputs 0, IDLE next cycle.
REQ-034 start_in held high through DONE with 15/4 then 9/9 -> two done_out pulses 9 edges apart, results 0x03/0x03 then 0x01/0x00.
